// File: rtl/word_pkg.sv
// rtl/word_pkg.sv - shared sizes and types for the word mask encoder
package word_pkg;

    localparam int N_WORDS = 8;
    localparam int IDX_W   = $clog2(N_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    typedef logic [N_WORDS-1:0] word_mask_t;
    typedef logic [IDX_W-1:0]   word_idx_t;

endpackage

// File: rtl/word_prio_enc.sv
// rtl/word_prio_enc.sv - combinational lowest-set-bit encoder for a word mask
module word_prio_enc
    import word_pkg::*;
(
    input  logic [N_WORDS-1:0] mask,
    output logic [IDX_W-1:0]   idx,
    output logic               any,
    output logic               single
);

    // scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx = '0;
        for (int i = N_WORDS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any    = |mask;
    assign single = any && ((mask & (mask - 1'b1)) == '0);

endmodule

// File: rtl/word_mask_encoder.sv
// rtl/word_mask_encoder.sv - word mask to word index stream, lowest first; optional WORD_ENC_ONEHOT_EN one-hot output
module word_mask_encoder
    import word_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_WORDS-1:0] mask_in,
    output logic               busy,
    output logic [IDX_W-1:0]   idx_out,
    output logic               idx_valid,
    input  logic               idx_ready,
    output logic               idx_last,
`ifdef WORD_ENC_ONEHOT_EN
    output logic [N_WORDS-1:0] word_enable_out,
`endif
    output logic               done
);

    enc_state_t state;
    word_mask_t pend;
    word_mask_t pend_next;
    word_idx_t  enc_idx;
    logic       enc_any;
    logic       enc_single;

    // value pend takes at the next edge; the encoder looks ahead at it so the
    // following index is ready in the same cycle as the transfer
    always_comb begin
        pend_next = pend;
        case (state)
            IDLE: if (start) pend_next = mask_in;
            EMIT: if (idx_ready) pend_next = pend & ~(word_mask_t'(1) << idx_out);
            default: pend_next = '0;
        endcase
    end

    word_prio_enc u_prio (
        .mask   (pend_next),
        .idx    (enc_idx),
        .any    (enc_any),
        .single (enc_single)
    );

    // sequencing FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pend      <= '0;
            idx_out   <= '0;
            idx_valid <= 1'b0;
            idx_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef WORD_ENC_ONEHOT_EN
            word_enable_out <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pend <= pend_next;
                        busy <= 1'b1;
                        if (enc_any) begin
                            state     <= EMIT;
                            idx_out   <= enc_idx;
                            idx_last  <= enc_single;
                            idx_valid <= 1'b1;
`ifdef WORD_ENC_ONEHOT_EN
                            word_enable_out <= word_mask_t'(1) << enc_idx;
`endif
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (idx_ready) begin
                        pend <= pend_next;
                        if (enc_any) begin
                            idx_out  <= enc_idx;
                            idx_last <= enc_single;
`ifdef WORD_ENC_ONEHOT_EN
                            word_enable_out <= word_mask_t'(1) << enc_idx;
`endif
                        end else begin
                            state     <= DONE;
                            idx_valid <= 1'b0;
                            idx_last  <= 1'b0;
                            idx_out   <= '0;
                            done      <= 1'b1;
`ifdef WORD_ENC_ONEHOT_EN
                            word_enable_out <= '0;
`endif
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    pend      <= '0;
                    idx_valid <= 1'b0;
                    idx_last  <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_mask_encoder.sv
// tb/tb_word_mask_encoder.sv - directed self-checking bench for word_mask_encoder
module tb_word_mask_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] mask_in;
    logic       busy;
    logic [2:0] idx_out;
    logic       idx_valid;
    logic       idx_ready;
    logic       idx_last;
    logic       done;
`ifdef WORD_ENC_ONEHOT_EN
    logic [7:0] word_enable_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    word_mask_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mask_in   (mask_in),
        .busy      (busy),
        .idx_out   (idx_out),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .idx_last  (idx_last),
`ifdef WORD_ENC_ONEHOT_EN
        .word_enable_out (word_enable_out),
`endif
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // checks valid/idx/last/busy/done together
    task automatic expect_out(input string tag, input logic v, input logic [2:0] i,
                              input logic l, input logic b, input logic d);
        check({tag, ".valid"}, 32'(idx_valid), 32'(v));
        if (v) check({tag, ".idx"}, 32'(idx_out), 32'(i));
        check({tag, ".last"}, 32'(idx_last), 32'(l));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(d));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        mask_in   = 8'h00;
        idx_ready = 1'b0;
        step();
        expect_out("reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check("reset.idx_out", 32'(idx_out), 32'd0);
        rst_n = 1'b1;
        step();

        // 1: mask A4, ready held high -> 2,5,7 then done
        idx_ready = 1'b1;
        mask_in = 8'hA4; start = 1'b1;
        step(); start = 1'b0;
        expect_out("t1.i2", 1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        step();
        expect_out("t1.i5", 1'b1, 3'd5, 1'b0, 1'b1, 1'b0);
        step();
        expect_out("t1.i7", 1'b1, 3'd7, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("t1.done", 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        step();
        expect_out("t1.idle", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        // 2: empty mask -> done next cycle, busy for that cycle only
        mask_in = 8'h00; start = 1'b1;
        step(); start = 1'b0;
        expect_out("t2.done", 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        step();
        expect_out("t2.idle", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        // 3: mask 81 with back-pressure for 3 cycles
        idx_ready = 1'b0;
        mask_in = 8'h81; start = 1'b1;
        step(); start = 1'b0;
        expect_out("t3.hold0", 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        step();
        expect_out("t3.hold1", 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        step();
        expect_out("t3.hold2", 1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        idx_ready = 1'b1;
        step();
        expect_out("t3.i7", 1'b1, 3'd7, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("t3.done", 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        step();

        // 4: restart attempt while busy is ignored; start in DONE ignored too
        mask_in = 8'h06; start = 1'b1;
        step();
        expect_out("t4.i1", 1'b1, 3'd1, 1'b0, 1'b1, 1'b0);
        mask_in = 8'hFF;
        step(); start = 1'b0;
        expect_out("t4.i2", 1'b1, 3'd2, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("t4.done", 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        mask_in = 8'h01; start = 1'b1;
        step(); start = 1'b0;
        expect_out("t4.done_start", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        step();
        expect_out("t4.still_idle", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        // 5: asynchronous reset mid-sequence
        mask_in = 8'hF0; start = 1'b1;
        step(); start = 1'b0;
        expect_out("t5.i4", 1'b1, 3'd4, 1'b0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        expect_out("t5.async", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check("t5.async.idx_out", 32'(idx_out), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        expect_out("t5.no_done", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        mask_in = 8'h01; start = 1'b1;
        step(); start = 1'b0;
        expect_out("t5.i0", 1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        step();
        expect_out("t5.done", 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        step();

        // all ones: 0..7 in order, last only on 7
        mask_in = 8'hFF; start = 1'b1;
        step(); start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            expect_out($sformatf("ff.i%0d", k), 1'b1, 3'(k), (k == 7), 1'b1, 1'b0);
            step();
        end
        expect_out("ff.done", 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
        step();

`ifdef WORD_ENC_ONEHOT_EN
        // 6: one-hot word enable follows the presented index
        check("t6.idle_we", 32'(word_enable_out), 32'h00);
        mask_in = 8'h28; start = 1'b1;
        step(); start = 1'b0;
        check("t6.we3", 32'(word_enable_out), 32'h08);
        step();
        check("t6.we5", 32'(word_enable_out), 32'h20);
        step();
        check("t6.we_done", 32'(word_enable_out), 32'h00);
        step();
        check("t6.we_idle", 32'(word_enable_out), 32'h00);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
